// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants: FSM state encoding, queue entry
// layout, reset PC default and the sequential PC increment.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage: power-of-two circular buffer of {instr, pc}
// entries with a flush that empties it in one cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 din,
    input  logic                         pop,
    output fetch_entry_t                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    // Flush wins over any same-cycle push or pop
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: single-outstanding memory requester with
// redirect handling, feeding a small queue of {instr, pc} to decode.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_ack,
    input  logic [31:0]                  imem_data,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_pc4,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e   state_q;
    fetch_state_e   state_d;
    logic [31:0]    addr_q;
    logic [31:0]    addr_d;
    logic [31:0]    pend_q;
    logic [31:0]    pend_d;
    logic           req_q;
    logic           req_d;

    logic           acc;
    logic [31:0]    redir_al;
    logic           push;
    logic           pop;
    logic           flush;
    logic [CW-1:0]  count_d;
    logic           fifo_full;
    logic           fifo_empty;
    fetch_entry_t   push_entry;
    fetch_entry_t   head;

    assign acc      = req_q & imem_ack;
    assign redir_al = align_word(redirect_pc);

    // State register plus the registered request/address outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            addr_q  <= RESET_PC;
            pend_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
        end
    end

    // Next-state: any issued-but-unacked request must be drained through DROP
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (req_q && !imem_ack) begin
                    state_d = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_d = FETCH;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Datapath controls and next values of the registered outputs
    always_comb begin
        addr_d = addr_q;
        pend_d = pend_q;
        push   = 1'b0;
        flush  = redirect;
        pop    = out_valid & out_ready & ~redirect;

        if (redirect) begin
            pend_d = redir_al;
        end

        unique case (state_q)
            FETCH, WAIT: begin
                if (redirect) begin
                    if (state_d == FETCH) begin
                        addr_d = redir_al;
                    end
                end else if (acc) begin
                    push   = ~fifo_full;
                    addr_d = addr_q + PC_INC;
                end
            end
            DROP: begin
                if (acc) begin
                    addr_d = redirect ? redir_al : pend_q;
                end
            end
            default: addr_d = addr_q;
        endcase

        // Occupancy after this edge reserves the slot for the next request
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count + CW'(push) - CW'(pop);
        end
        req_d = (state_d != FETCH) || (count_d < CW'(DEPTH));
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    assign push_entry.instr = imem_data;
    assign push_entry.pc    = addr_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign out_valid = ~fifo_empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign out_pc4   = head.pc + PC_INC;

endmodule
